// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU: EX/MEM and MEM/WB forwarding, one bubble on load-use, flush from branch resolution.
// Latency ID->ALU operands 1 cycle; holds while mem_ready_i=0 and backpressures ID through ex_ready_o.
// Optional EX_STALL_CNT_EN adds stall_cnt_o, a wrapping count of cycles in which ID was stalled.
module ex_operand_stage #(
   parameter int XLEN  = 32,
   parameter int REGW  = 5,
   parameter int CTRLW = 12
) (
   input  logic             clk_i,
   input  logic             rst_i,
`ifdef EX_STALL_CNT_EN
   output logic [31:0]      stall_cnt_o,
`endif
   input  logic             id_valid_i,
   output logic             ex_ready_o,
   input  logic [XLEN-1:0]  id_pc_i,
   input  logic [REGW-1:0]  id_rs1_i,
   input  logic [REGW-1:0]  id_rs2_i,
   input  logic [XLEN-1:0]  id_rs1_data_i,
   input  logic [XLEN-1:0]  id_rs2_data_i,
   input  logic [XLEN-1:0]  id_imm_i,
   input  logic             id_use_imm_i,
   input  logic [REGW-1:0]  id_rd_i,
   input  logic             id_reg_we_i,
   input  logic             id_mem_read_i,
   input  logic             id_branch_i,
   input  logic [CTRLW-1:0] id_alu_ctrl_i,
   input  logic             mem_ready_i,
   input  logic             flush_i,
   input  logic             exm_we_i,
   input  logic [REGW-1:0]  exm_rd_i,
   input  logic [XLEN-1:0]  exm_data_i,
   input  logic             wb_we_i,
   input  logic [REGW-1:0]  wb_rd_i,
   input  logic [XLEN-1:0]  wb_data_i,
   output logic             ex_valid_o,
   output logic [XLEN-1:0]  src1_o,
   output logic [XLEN-1:0]  src2_o,
   output logic [XLEN-1:0]  ex_store_data_o,
   output logic [CTRLW-1:0] ex_alu_ctrl_o,
   output logic [XLEN-1:0]  ex_pc_o,
   output logic [XLEN-1:0]  ex_imm_o,
   output logic [REGW-1:0]  ex_rd_o,
   output logic             ex_reg_we_o,
   output logic             ex_mem_read_o,
   output logic             ex_branch_o
);

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  rs1_data;
      logic [XLEN-1:0]  rs2_data;
      logic [REGW-1:0]  rs1;
      logic [REGW-1:0]  rs2;
      logic [REGW-1:0]  rd;
      logic             use_imm;
      logic             reg_we;
      logic             mem_read;
      logic             branch;
      logic [CTRLW-1:0] alu_ctrl;
   } ex_regs_t;

   ex_regs_t ex_q;
   logic     valid_q;
   logic     hazard;
   logic     capture;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   assign hazard = valid_q & ex_q.mem_read & (ex_q.rd != '0) & id_valid_i &
                   ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i));
   assign ex_ready_o = (~valid_q | mem_ready_i) & ~hazard;
   assign capture    = id_valid_i & ex_ready_o;

   // Bubble and normal drain both just clear valid; only capture reloads fields
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         ex_q    <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (capture) begin
         valid_q          <= 1'b1;
         ex_q.pc          <= id_pc_i;
         ex_q.imm         <= id_imm_i;
         ex_q.rs1_data    <= id_rs1_data_i;
         ex_q.rs2_data    <= id_rs2_data_i;
         ex_q.rs1         <= id_rs1_i;
         ex_q.rs2         <= id_rs2_i;
         ex_q.rd          <= id_rd_i;
         ex_q.use_imm     <= id_use_imm_i;
         ex_q.reg_we      <= id_reg_we_i;
         ex_q.mem_read    <= id_mem_read_i;
         ex_q.branch      <= id_branch_i;
         ex_q.alu_ctrl    <= id_alu_ctrl_i;
      end else if (valid_q & mem_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   // EX/MEM is younger than MEM/WB, so it wins when both target the same register
   always_comb begin
      fwd_rs1 = ex_q.rs1_data;
      if (ex_q.rs1 == '0)
         fwd_rs1 = '0;
      else if (exm_we_i && exm_rd_i == ex_q.rs1)
         fwd_rs1 = exm_data_i;
      else if (wb_we_i && wb_rd_i == ex_q.rs1)
         fwd_rs1 = wb_data_i;

      fwd_rs2 = ex_q.rs2_data;
      if (ex_q.rs2 == '0)
         fwd_rs2 = '0;
      else if (exm_we_i && exm_rd_i == ex_q.rs2)
         fwd_rs2 = exm_data_i;
      else if (wb_we_i && wb_rd_i == ex_q.rs2)
         fwd_rs2 = wb_data_i;
   end

   assign ex_valid_o      = valid_q;
   assign src1_o          = fwd_rs1;
   assign src2_o          = ex_q.use_imm ? ex_q.imm : fwd_rs2;
   assign ex_store_data_o = fwd_rs2;
   assign ex_alu_ctrl_o   = ex_q.alu_ctrl;
   assign ex_pc_o         = ex_q.pc;
   assign ex_imm_o        = ex_q.imm;
   assign ex_rd_o         = ex_q.rd;
   assign ex_reg_we_o     = valid_q & ex_q.reg_we;
   assign ex_mem_read_o   = valid_q & ex_q.mem_read;
   assign ex_branch_o     = valid_q & ex_q.branch;

`ifdef EX_STALL_CNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i)
         stall_cnt_o <= '0;
      else if (id_valid_i & ~ex_ready_o & ~flush_i)
         stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: driver queues expected EX results, monitor compares them on handshake.
module tb_ex_operand_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        id_valid_i;
   logic        ex_ready_o;
   logic [31:0] id_pc_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
   logic        id_use_imm_i, id_reg_we_i, id_mem_read_i, id_branch_i;
   logic [11:0] id_alu_ctrl_i;
   logic        mem_ready_i, flush_i;
   logic        exm_we_i, wb_we_i;
   logic [4:0]  exm_rd_i, wb_rd_i;
   logic [31:0] exm_data_i, wb_data_i;
   logic        ex_valid_o;
   logic [31:0] src1_o, src2_o, ex_store_data_o, ex_pc_o, ex_imm_o;
   logic [11:0] ex_alu_ctrl_o;
   logic [4:0]  ex_rd_o;
   logic        ex_reg_we_o, ex_mem_read_o, ex_branch_o;
`ifdef EX_STALL_CNT_EN
   logic [31:0] stall_cnt_o;
`endif

   ex_operand_stage dut (
      .clk_i(clk_i), .rst_i(rst_i),
`ifdef EX_STALL_CNT_EN
      .stall_cnt_o(stall_cnt_o),
`endif
      .id_valid_i(id_valid_i), .ex_ready_o(ex_ready_o), .id_pc_i(id_pc_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
      .id_imm_i(id_imm_i), .id_use_imm_i(id_use_imm_i), .id_rd_i(id_rd_i),
      .id_reg_we_i(id_reg_we_i), .id_mem_read_i(id_mem_read_i), .id_branch_i(id_branch_i),
      .id_alu_ctrl_i(id_alu_ctrl_i), .mem_ready_i(mem_ready_i), .flush_i(flush_i),
      .exm_we_i(exm_we_i), .exm_rd_i(exm_rd_i), .exm_data_i(exm_data_i),
      .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .ex_valid_o(ex_valid_o), .src1_o(src1_o), .src2_o(src2_o),
      .ex_store_data_o(ex_store_data_o), .ex_alu_ctrl_o(ex_alu_ctrl_o),
      .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o),
      .ex_reg_we_o(ex_reg_we_o), .ex_mem_read_o(ex_mem_read_o), .ex_branch_o(ex_branch_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc, s1, s2, st;
      logic [4:0]  rd;
      logic        we, mr, br;
      logic [11:0] ctrl;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic ui, input logic [4:0] rd, input logic we, input logic mr,
                         input logic br, input logic [11:0] ctrl);
      id_valid_i = v; id_pc_i = pc; id_rs1_i = rs1; id_rs2_i = rs2;
      id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm; id_use_imm_i = ui;
      id_rd_i = rd; id_reg_we_i = we; id_mem_read_i = mr; id_branch_i = br; id_alu_ctrl_i = ctrl;
   endtask

   task automatic id_idle();
      id_set(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 12'h0);
   endtask

   task automatic expect_ex(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] st, input logic [4:0] rd, input logic we,
                            input logic mr, input logic br, input logic [11:0] ctrl);
      exp_t e;
      e.pc = pc; e.s1 = s1; e.s2 = s2; e.st = st; e.rd = rd;
      e.we = we; e.mr = mr; e.br = br; e.ctrl = ctrl;
      exp_q.push_back(e);
   endtask

   // Monitor: every EX instruction handed to MEM must match the oldest expectation
   always @(negedge clk_i) begin
      if (rst_i === 1'b0 && ex_valid_o === 1'b1 && mem_ready_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ex: pc 0x%08h presented, none required", ex_pc_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ex_pc", ex_pc_o, e.pc);
            chk("src1", src1_o, e.s1);
            chk("src2", src2_o, e.s2);
            chk("store_data", ex_store_data_o, e.st);
            chk("rd", {27'd0, ex_rd_o}, {27'd0, e.rd});
            chk("flags", {29'd0, ex_reg_we_o, ex_mem_read_o, ex_branch_o}, {29'd0, e.we, e.mr, e.br});
            chk("alu_ctrl", {20'd0, ex_alu_ctrl_o}, {20'd0, e.ctrl});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; mem_ready_i = 1'b1; flush_i = 1'b0;
      exm_we_i = 1'b0; exm_rd_i = 5'd0; exm_data_i = 32'h0;
      wb_we_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'h0;
      id_idle();
      tick(); tick();
      chk("rst_valid", {31'd0, ex_valid_o}, 32'd0);
      chk("rst_pc", ex_pc_o, 32'h0);
      chk("rst_src1", src1_o, 32'h0);
      chk("rst_ready", {31'd0, ex_ready_o}, 32'd1);
      rst_i = 1'b0;

      // ADDI x1,x0,5 then ADD x2,x1,x1 forwarded from EX/MEM
      id_set(1, 32'h100, 5'd0, 5'd0, 32'h0, 32'h0, 32'd5, 1, 5'd1, 1, 0, 0, 12'h001);
      expect_ex(32'h100, 32'h0, 32'd5, 32'h0, 5'd1, 1, 0, 0, 12'h001);
      tick();
      id_set(1, 32'h104, 5'd1, 5'd1, 32'hDEAD, 32'hDEAD, 32'h0, 0, 5'd2, 1, 0, 0, 12'h002);
      #1 chk("t1_no_stall", {31'd0, ex_ready_o}, 32'd1);
      expect_ex(32'h104, 32'd5, 32'd5, 32'd5, 5'd2, 1, 0, 0, 12'h002);
      tick();
      id_idle();
      exm_we_i = 1'b1; exm_rd_i = 5'd1; exm_data_i = 32'd5;
      tick();

      // LW x3 then ADD x4,x3,x3: one bubble, then MEM/WB forward
      exm_we_i = 1'b0;
      id_set(1, 32'h200, 5'd0, 5'd0, 32'h0, 32'h0, 32'h40, 1, 5'd3, 1, 1, 0, 12'h003);
      expect_ex(32'h200, 32'h0, 32'h40, 32'h0, 5'd3, 1, 1, 0, 12'h003);
      tick();
      id_set(1, 32'h204, 5'd3, 5'd3, 32'h111, 32'h111, 32'h0, 0, 5'd4, 1, 0, 0, 12'h004);
      #1 chk("t2_hazard_ready", {31'd0, ex_ready_o}, 32'd0);
      tick();
      #1 chk("t2_bubble_valid", {31'd0, ex_valid_o}, 32'd0);
      chk("t2_after_bubble_ready", {31'd0, ex_ready_o}, 32'd1);
      expect_ex(32'h204, 32'h12345678, 32'h12345678, 32'h12345678, 5'd4, 1, 0, 0, 12'h004);
      tick();
      id_idle();
      wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'h12345678;
      tick();

      // EX/MEM beats MEM/WB on x5; x0 never forwards
      wb_we_i = 1'b0;
      id_set(1, 32'h208, 5'd5, 5'd0, 32'h999, 32'h777, 32'h0, 0, 5'd6, 1, 0, 0, 12'h005);
      expect_ex(32'h208, 32'hA, 32'h0, 32'h0, 5'd6, 1, 0, 0, 12'h005);
      tick();
      exm_we_i = 1'b1; exm_rd_i = 5'd5; exm_data_i = 32'hA;
      wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hB;
      id_set(1, 32'h20C, 5'd0, 5'd5, 32'h55, 32'h66, 32'h0, 0, 5'd7, 1, 0, 0, 12'h006);
      expect_ex(32'h20C, 32'h0, 32'h66, 32'h66, 5'd7, 1, 0, 0, 12'h006);
      tick();
      exm_we_i = 1'b0;
      wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hBAD;
      id_set(1, 32'h210, 5'd1, 5'd2, 32'h10, 32'h20, 32'h0, 0, 5'd8, 1, 0, 0, 12'h007);
      expect_ex(32'h210, 32'h10, 32'h20, 32'h20, 5'd8, 1, 0, 0, 12'h007);
      tick();

      // Three cycles of MEM backpressure
      wb_we_i = 1'b0;
      mem_ready_i = 1'b0;
      id_set(1, 32'h214, 5'd3, 5'd4, 32'h30, 32'h40, 32'h0, 0, 5'd9, 1, 0, 0, 12'h008);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_hold_ready", {31'd0, ex_ready_o}, 32'd0);
         chk("t4_hold_valid", {31'd0, ex_valid_o}, 32'd1);
         chk("t4_hold_pc", ex_pc_o, 32'h210);
         chk("t4_hold_src1", src1_o, 32'h10);
         chk("t4_hold_src2", src2_o, 32'h20);
         chk("t4_hold_rd", {27'd0, ex_rd_o}, 32'd8);
         tick();
      end
      mem_ready_i = 1'b1;
      #1 chk("t4_release_ready", {31'd0, ex_ready_o}, 32'd1);
      expect_ex(32'h214, 32'h30, 32'h40, 32'h40, 5'd9, 1, 0, 0, 12'h008);
      tick();

      // Flush kills EX and drops the ID instruction despite handshake
      id_set(1, 32'h500, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 0, 5'd12, 1, 0, 1, 12'h009);
      expect_ex(32'h500, 32'h0, 32'h0, 32'h0, 5'd12, 1, 0, 1, 12'h009);
      tick();
      flush_i = 1'b1;
      id_set(1, 32'h400, 5'd1, 5'd1, 32'h1, 32'h1, 32'h0, 0, 5'd10, 1, 0, 1, 12'h00A);
      #1 chk("t5_ready_at_flush", {31'd0, ex_ready_o}, 32'd1);
      tick();
      flush_i = 1'b0;
      #1 chk("t5_valid", {31'd0, ex_valid_o}, 32'd0);
      chk("t5_flags", {29'd0, ex_reg_we_o, ex_mem_read_o, ex_branch_o}, 32'd0);

      // Reset in the middle of a hold
      id_set(1, 32'h600, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4, 1, 5'd11, 1, 1, 0, 12'h00B);
      tick();
      id_idle();
      mem_ready_i = 1'b0;
      #1 chk("t6_pre_valid", {31'd0, ex_valid_o}, 32'd1);
      chk("t6_pre_memread", {31'd0, ex_mem_read_o}, 32'd1);
`ifdef EX_STALL_CNT_EN
      chk("stall_cnt", stall_cnt_o, 32'd4);
`endif
      tick();
      rst_i = 1'b1;
      id_set(1, 32'h604, 5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 0, 5'd13, 1, 0, 0, 12'h00C);
      tick();
      rst_i = 1'b0;
      id_idle();
      mem_ready_i = 1'b1;
      #1;
      chk("t6_valid", {31'd0, ex_valid_o}, 32'd0);
      chk("t6_pc", ex_pc_o, 32'h0);
      chk("t6_imm", ex_imm_o, 32'h0);
      chk("t6_src2", src2_o, 32'h0);
      chk("t6_store", ex_store_data_o, 32'h0);
      chk("t6_ctrl", {20'd0, ex_alu_ctrl_o}, 32'd0);
      chk("t6_rd", {27'd0, ex_rd_o}, 32'd0);
      chk("t6_flags", {29'd0, ex_reg_we_o, ex_mem_read_o, ex_branch_o}, 32'd0);
`ifdef EX_STALL_CNT_EN
      chk("t6_stall_cnt", stall_cnt_o, 32'd0);
`endif
      tick(); tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
